// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [5:0] HALT_OP = 6'b111111;
  function automatic logic [5:0] opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, IMEM and IF/ID signals of the fetch stage
interface fetch_stage_if;
  logic start;
  logic stall;
  logic redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_next;
  logic halted;
  logic [31:0] fetch_count;
  modport master (
    input start, stall, redirect, redirect_pc, imem_instr,
    output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_next, halted, fetch_count
  );
  modport slave (
    output start, stall, redirect, redirect_pc, imem_instr,
    input imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_next, halted, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, neither means hold
module if_id_reg import fetch_pkg::*; (
  input logic clk,
  input logic rst,
  input logic load,
  input logic flush,
  input logic [31:0] instr,
  input logic [31:0] pc,
  output logic valid,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic [31:0] pc_next_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr_q <= NOP_WORD;
      pc_q <= 32'd0;
      pc_next_q <= 32'd0;
    end else if (flush) begin
      valid <= 1'b0;
      instr_q <= NOP_WORD;
    end else if (load) begin
      valid <= 1'b1;
      instr_q <= instr;
      pc_q <= pc;
      pc_next_q <= pc + 32'd1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, start/halt FSM and fetch counter feeding the IF/ID register
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.master bus
);
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, count;
  logic run, halt_cap, load, flush;
  logic valid;
  logic [31:0] instr_q, pc_q, pc_next_q;
  // a halt word sitting valid in IF/ID outranks redirect and stall
  always_comb begin
    run = state == RUN;
    halt_cap = run && valid && opcode(instr_q) == HALT_OP;
    load = run && !halt_cap && !bus.redirect && !bus.stall;
    flush = !run || halt_cap || bus.redirect;
    state_nx = (state == IDLE && bus.start) ? RUN : halt_cap ? HALT : state;
    pc_nx = (run && !halt_cap && bus.redirect) ? bus.redirect_pc : load ? pc + 32'd1 : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      count <= 32'd0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      count <= count + {31'd0, load};
    end
  end
  if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(flush),
    .instr(bus.imem_instr),
    .pc(pc),
    .valid(valid),
    .instr_q(instr_q),
    .pc_q(pc_q),
    .pc_next_q(pc_next_q)
  );
  assign bus.imem_addr = pc;
  assign bus.if_id_valid = valid;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc = pc_q;
  assign bus.if_id_pc_next = pc_next_q;
  assign bus.halted = state == HALT;
  assign bus.fetch_count = count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch, stall, redirect, wrap, reset and halt
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [16];
  fetch_stage_if bus ();
  fetch_stage #(.RESET_PC(32'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_instr = mem[bus.imem_addr[3:0]];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0022_1820;
    mem[1] = 32'h2109_000A;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("rst_instr", bus.if_id_instr, 32'h0);
    chk("rst_pc", bus.if_id_pc, 32'd0);
    chk("rst_pc_next", bus.if_id_pc_next, 32'd0);
    chk("rst_count", bus.fetch_count, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    tick();
    chk("idle_addr", bus.imem_addr, 32'd0);
    chk("idle_valid", {31'd0, bus.if_id_valid}, 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_addr", bus.imem_addr, 32'd0);
    chk("start_valid", {31'd0, bus.if_id_valid}, 32'd0);
    tick();
    chk("f0_instr", bus.if_id_instr, 32'h0022_1820);
    chk("f0_pc", bus.if_id_pc, 32'd0);
    chk("f0_pc_next", bus.if_id_pc_next, 32'd1);
    chk("f0_valid", {31'd0, bus.if_id_valid}, 32'd1);
    chk("f0_count", bus.fetch_count, 32'd1);
    tick();
    chk("f1_instr", bus.if_id_instr, 32'h2109_000A);
    chk("f1_pc", bus.if_id_pc, 32'd1);
    chk("f1_count", bus.fetch_count, 32'd2);
    chk("f1_addr", bus.imem_addr, 32'd2);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", bus.imem_addr, 32'd2);
      chk("stall_pc", bus.if_id_pc, 32'd1);
      chk("stall_count", bus.fetch_count, 32'd2);
      chk("stall_valid", {31'd0, bus.if_id_valid}, 32'd1);
      chk("stall_instr", bus.if_id_instr, 32'h2109_000A);
    end
    bus.stall = 1'b0;
    tick();
    chk("resume_pc", bus.if_id_pc, 32'd2);
    chk("resume_instr", bus.if_id_instr, 32'h1000_0002);
    chk("resume_count", bus.fetch_count, 32'd3);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd9;
    bus.stall = 1'b1;
    tick();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    chk("redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("redir_instr", bus.if_id_instr, 32'h0);
    chk("redir_addr", bus.imem_addr, 32'd9);
    chk("redir_count", bus.fetch_count, 32'd3);
    tick();
    chk("redir_pc", bus.if_id_pc, 32'd9);
    chk("redir_fetch", bus.if_id_instr, 32'h1000_0009);
    chk("redir_count2", bus.fetch_count, 32'd4);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_pc", bus.if_id_pc, 32'hFFFF_FFFF);
    chk("wrap_pc_next", bus.if_id_pc_next, 32'd0);
    chk("wrap_instr", bus.if_id_instr, 32'h1000_000F);
    chk("wrap_count", bus.fetch_count, 32'd5);
    tick();
    chk("wrap_pc0", bus.if_id_pc, 32'd0);
    chk("wrap_instr0", bus.if_id_instr, 32'h0022_1820);
    chk("wrap_count6", bus.fetch_count, 32'd6);
    rst = 1'b1;
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd5;
    tick();
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    chk("mrst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("mrst_instr", bus.if_id_instr, 32'h0);
    chk("mrst_pc", bus.if_id_pc, 32'd0);
    chk("mrst_pc_next", bus.if_id_pc_next, 32'd0);
    chk("mrst_count", bus.fetch_count, 32'd0);
    chk("mrst_addr", bus.imem_addr, 32'd0);
    tick();
    chk("mrst_idle_addr", bus.imem_addr, 32'd0);
    chk("mrst_idle_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("mrst_idle_count", bus.fetch_count, 32'd0);
    mem[3] = {6'b111111, 26'd0};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_run_pc", bus.if_id_pc, i);
      chk("halt_run_valid", {31'd0, bus.if_id_valid}, 32'd1);
    end
    chk("halt_cap_instr", bus.if_id_instr, 32'hFC00_0000);
    chk("halt_cap_count", bus.fetch_count, 32'd4);
    chk("halt_cap_addr", bus.imem_addr, 32'd4);
    chk("halt_cap_halted", {31'd0, bus.halted}, 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd7;
    bus.stall = 1'b1;
    tick();
    chk("halt_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("halt_instr", bus.if_id_instr, 32'h0);
    chk("halt_addr", bus.imem_addr, 32'd4);
    chk("halt_count", bus.fetch_count, 32'd4);
    bus.stall = 1'b0;
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    bus.redirect = 1'b0;
    chk("halt_hold_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_hold_addr", bus.imem_addr, 32'd4);
    chk("halt_hold_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("halt_hold_count", bus.fetch_count, 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
